// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared SECDED helpers: code geometry and flag record
package hamming_pkg;

    // Smallest r with 2^r >= data_w + r + 1 (Hamming bound, excluding overall parity)
    function automatic int calc_parity_w(input int data_w);
        int r;
        r = 0;
        for (int i = 1; i < 8; i++) begin
            if (r == 0 && (1 << i) >= data_w + i + 1) begin
                r = i;
            end
        end
        return r;
    endfunction

    function automatic logic is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Data index -> code position: the k-th non-power-of-2 position starting at 3
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 3; i < 128; i++) begin
            if (!is_pow2(i)) begin
                if (cnt == k && pos == 0) begin
                    pos = i;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

    // Per-word classification carried from the syndrome stage into the output stage
    typedef struct packed {
        logic sec;   // single error seen
        logic ded;   // uncorrectable error seen
        logic fix;   // single error and correction enabled
    } flag_t;

endpackage

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - combinational codeword to syndrome and overall parity
module hamming_syndrome #(
    parameter int CODE_W   = 16,
    parameter int PARITY_W = 4
) (
    input  logic [CODE_W-1:0]   code,
    output logic [PARITY_W-1:0] syndrome,
    output logic                parity
);

    // XOR of the indices of every set bit gives the error position; bit 0 carries no index
    always_comb begin
        syndrome = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (code[i]) begin
                syndrome = syndrome ^ PARITY_W'(i);
            end
        end
        parity = ^code;
    end

endmodule

// File: rtl/hamming_secded_decoder.sv
// rtl/hamming_secded_decoder.sv - pipelined SECDED decoder with saturating error counters
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int  DATA_W   = 11,
    parameter int  CNT_W    = 16,
    localparam int PARITY_W = calc_parity_w(DATA_W),
    localparam int CODE_W   = DATA_W + PARITY_W + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   in_code,
    input  logic                correct_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_sec,
    output logic                out_ded,
    output logic [PARITY_W-1:0] out_syndrome,
    input  logic                clr_cnt,
    output logic [CNT_W-1:0]    sec_count,
    output logic [CNT_W-1:0]    ded_count
);

    logic [PARITY_W-1:0] in_syn;
    logic                in_par;
    logic [DATA_W-1:0]   in_data_raw;

    // S1 keeps only the data positions of the codeword; parity positions never reach the output
    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;
    logic [PARITY_W-1:0] s1_syn;
    logic                s1_par;
    logic                s1_cen;

    flag_t               cls;
    logic [DATA_W-1:0]   fixed_data;
    logic                s2_adv;
    logic                out_hs;

    hamming_syndrome #(
        .CODE_W   (CODE_W),
        .PARITY_W (PARITY_W)
    ) u_syndrome (
        .code     (in_code),
        .syndrome (in_syn),
        .parity   (in_par)
    );

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign out_hs   = out_valid && out_ready;

    // Pull the data bits out of their Hamming positions
    always_comb begin
        in_data_raw = '0;
        for (int k = 0; k < DATA_W; k++) begin
            in_data_raw[k] = in_code[data_pos(k)];
        end
    end

    // Classify the word and flip the erroneous data bit when correction applies
    always_comb begin
        cls     = '0;
        cls.sec = s1_par && (int'(s1_syn) < CODE_W);
        cls.ded = (!s1_par && (s1_syn != '0)) || (s1_par && (int'(s1_syn) >= CODE_W));
        cls.fix = cls.sec && s1_cen;
        fixed_data = '0;
        for (int k = 0; k < DATA_W; k++) begin
            fixed_data[k] = s1_data[k] ^ (cls.fix && (int'(s1_syn) == data_pos(k)));
        end
    end

    // Stage 1: capture the word and its syndrome whenever the stage can move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
            s1_cen   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data_raw;
                s1_syn  <= in_syn;
                s1_par  <= in_par;
                s1_cen  <= correct_en;
            end
        end
    end

    // Stage 2: output register, held stable while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sec      <= 1'b0;
            out_ded      <= 1'b0;
            out_syndrome <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= fixed_data;
                out_sec      <= cls.sec;
                out_ded      <= cls.ded;
                out_syndrome <= s1_syn;
            end
        end
    end

    // Saturating error counters; a clear discards any same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (clr_cnt) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (out_hs) begin
            if (out_sec && (sec_count != '1)) begin
                sec_count <= sec_count + 1'b1;
            end
            if (out_ded && (ded_count != '1)) begin
                ded_count <= ded_count + 1'b1;
            end
        end
    end

endmodule
